cnn_mac_pipe: RTL
=================

Name: cnn_mac_pipe

Overview:
- Pipelined signed×unsigned multiply-accumulate engine.
- Next generation of the single-cycle 14s×8u multiplier primitive used in the conv and dense layers.
- Operand widths, pipeline depth and accumulator width are parametrised.
- Adds a valid/ready handshake with backpressure, group-based dot-product accumulation (first/last tags), protocol-error detection and optional saturation.

Parameters:
- A_W, 14, width of signed operand din0 (activation/weight in ap_fixed<14,6> format).
- B_W, 8, width of unsigned operand din1.
- NUM_STAGE, 3, number of product pipeline registers (legal range 1..6).
- ACC_W, 32, accumulator and result width; must be >= A_W+B_W+1.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat this cycle.
- din0  in  A_W  signed operand.
- din1  in  B_W  unsigned operand (zero-extended).
- in_first  in  1  beat opens a new accumulation group.
- in_last  in  1  beat closes the group; result is emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  ACC_W  signed accumulated result.
- err  out  1  one-cycle pulse on a protocol error.
- ovf  out  1  sticky overflow flag for the current result.

Behaviour:
- Reset (async assert, sync deassert internally):
  - out_valid=0, dout=0, err=0, ovf=0, in_ready=0 while reset is asserted.
  - All pipeline valid tags cleared, accumulator=0, state=IDLE.
- Stall:
  - en = !(out_valid && !out_ready); in_ready = en.
  - Beat accepted on in_valid && in_ready.
  - When en=0 every pipeline register, tag and the accumulator hold their values.
- Product:
  - P_W = A_W+B_W bits; p = signed(din0) × signed({1'b0,din1}).
  - Registered through NUM_STAGE stages together with valid/first/last tags.
- Accumulate stage (acts on a valid tag with en=1). FSM states:
  - IDLE: beat with first=1 → acc=sext(p), go to OPEN. Beat with first=0 → treat as first, err=1 for one cycle.
  - OPEN: first=0 → acc=acc+sext(p). first=1 → partial sum discarded, acc=sext(p), err=1.
  - A beat with last=1 (any state): load dout with the new acc value, out_valid=1, go to IDLE. A first&last beat gives dout = sext(p).
- Latency:
  - Last beat accepted at edge t → out_valid=1 after edge t+NUM_STAGE+1, with no stalls.
  - Throughput is one beat per cycle.
- Output:
  - out_valid drops on out_valid && out_ready unless a new result loads on the same edge, in which case it stays 1 with the new dout.
  - dout is stable while out_valid && !out_ready.
- Arithmetic:
  - Accumulation is two's complement at ACC_W bits.
  - Overflow is detected when the operand signs match and the result sign differs.
  - ovf is set on overflow, held until its result is accepted, and cleared when the next group opens.
- Reset mid-group: the group is lost, nothing is emitted, and the first post-reset group is unaffected.

Optional Feature:
- Macro: CNN_MAC_SAT_EN.
- Defined: on overflow the accumulator clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and later beats accumulate from the clamped value (ovf is still set).
- Undefined: the accumulator wraps modulo 2^ACC_W; ovf still reports.

Test Plan:
- Single beat first=last=1, din0=-3, din1=200, NUM_STAGE=3 → dout=-600 four cycles after acceptance; err=0, ovf=0.
- Group (100,2),(-50,4),(7,255), back-to-back → dout=1785 once; out_valid high exactly one cycle with out_ready=1.
- Two 3-beat groups back-to-back, out_ready=0 for 5 cycles after the first result → in_ready=0 during the hold, dout stays 1785; both results delivered in order with no beat lost.
- ACC_W=24, five beats of (-8192,255) (product -2088960, sum -10444800) → ovf=1; dout=6332416 without the macro, -8388608 with CNN_MAC_SAT_EN.
- From IDLE, beat first=0 last=1 (10,10) → err pulse for one cycle, dout=100. Mid-group first=1 → err pulse and the partial sum is discarded.
- Drive ap_rst_n low asynchronously mid-group → out_valid=0 and dout=0 immediately; after release a group (1,1) first&last → dout=1.

Source files
------------

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed x unsigned MAC with grouped dot-product
// accumulation, valid/ready backpressure, protocol error pulse and overflow flag.
// Ports: ap_clk, ap_rst_n (async low); in_valid/in_ready, din0 (signed A_W),
//   din1 (unsigned B_W), in_first/in_last; out_valid/out_ready, dout (ACC_W),
//   err (1-cycle pulse), ovf (sticky per result).
// Option: define CNN_MAC_SAT_EN to clamp the accumulator on overflow.
module cnn_mac_pipe #(
    parameter int A_W       = 14,
    parameter int B_W       = 8,
    parameter int NUM_STAGE = 3,
    parameter int ACC_W     = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] dout,
    output logic             err,
    output logic             ovf
);
    localparam int P_W = A_W + B_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OPEN = 1'b1;

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rs;
    logic       rst_n_i;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rs <= 2'b00;
        else           rs <= {rs[0], 1'b1};
    end
    assign rst_n_i = rs[1];

    logic en;
    logic accept;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en && rst_n_i;
    assign accept   = in_valid && in_ready;

    // Operand register feeding the multiplier.
    logic signed [A_W-1:0] a_q;
    logic [B_W-1:0]        b_q;
    logic                  v0, f0, l0;

    always_ff @(posedge ap_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q <= '0;
            b_q <= '0;
            v0  <= 1'b0;
            f0  <= 1'b0;
            l0  <= 1'b0;
        end else if (en) begin
            a_q <= din0;
            b_q <= din1;
            v0  <= accept;
            f0  <= in_first;
            l0  <= in_last;
        end
    end

    // din1 is zero-extended so the product is a plain signed multiply.
    logic signed [P_W-1:0] a_x, b_x, prod;
    assign a_x  = P_W'(a_q);
    assign b_x  = P_W'(b_q);
    assign prod = a_x * b_x;

    logic signed [P_W-1:0] p_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]  pv, pf, pl;

    always_ff @(posedge ap_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= '0;
            pv <= '0;
            pf <= '0;
            pl <= '0;
        end else if (en) begin
            p_q[0] <= prod;
            pv[0]  <= v0;
            pf[0]  <= f0;
            pl[0]  <= l0;
            for (int i = 1; i < NUM_STAGE; i++) begin
                p_q[i] <= p_q[i-1];
                pv[i]  <= pv[i-1];
                pf[i]  <= pf[i-1];
                pl[i]  <= pl[i-1];
            end
        end
    end

    logic                    vt, ft, lt;
    logic signed [ACC_W-1:0] pe, acc_q, sum, acc_n;
    logic [0:0]              state;
    logic                    o, open, ovf_n, err_n;

    assign vt = pv[NUM_STAGE-1];
    assign ft = pf[NUM_STAGE-1];
    assign lt = pl[NUM_STAGE-1];
    assign pe = ACC_W'(p_q[NUM_STAGE-1]);
    assign sum = acc_q + pe;
    assign o = (acc_q[ACC_W-1] == pe[ACC_W-1]) &&
               (sum[ACC_W-1] != acc_q[ACC_W-1]);
    // A beat in IDLE opens a group even without its first tag.
    assign open = (state == IDLE) || ft;

`ifdef CNN_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    always_comb begin
        acc_n = sum;
        ovf_n = ovf | o;
        err_n = 1'b0;
        if (open) begin
            acc_n = pe;
            ovf_n = 1'b0;
            err_n = (state == IDLE) ^ ft;
        end
`ifdef CNN_MAC_SAT_EN
        else if (o) begin
            acc_n = pe[ACC_W-1] ? MINV : MAXV;
        end
`endif
    end

    always_ff @(posedge ap_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            acc_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (en && vt) begin
                acc_q <= acc_n;
                ovf   <= ovf_n;
                err   <= err_n;
                state <= lt ? IDLE : OPEN;
            end
            if (en && vt && lt) begin
                dout      <= acc_n;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
